// File: rtl/emib_lane_prbs_chk_if.sv
// Received AIB lane bus as seen by the PRBS7 checker: one beat qualifier plus one bit per lane.
interface emib_lane_prbs_chk_if #(
    parameter int unsigned DWIDTH = 40
);
    logic              i_valid;
    logic [DWIDTH-1:0] i_data;

    modport master (output i_valid, output i_data);
    modport slave  (input  i_valid, input  i_data);
endinterface

// File: rtl/emib_lane_prbs_chk.sv
// Per-lane PRBS7 (x^7+x^6+1) checker: self-seeds from received data, hunts for lock,
// then free-runs a local generator per lane and counts/flags mismatching bits.
module emib_lane_prbs_chk #(
    parameter int unsigned DWIDTH     = 40,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned LOSS_BEATS = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    emib_lane_prbs_chk_if.slave rx,
    output logic                o_locked,
    output logic [ERR_W-1:0]    o_err_cnt,
    output logic [DWIDTH-1:0]   o_err_lane,
    output logic [DWIDTH-1:0]   o_stuck_lane,
    output logic [1:0]          o_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEED   = 2'd1;
    localparam logic [1:0] ST_HUNT   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam int unsigned PCW = $clog2(DWIDTH + 1);
    localparam int unsigned SW  = ((ERR_W > PCW) ? ERR_W : PCW) + 1;
    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [7:0]  LOSS_LAST = 8'(LOSS_BEATS - 1);

    logic [1:0]             state_q, state_d;
    logic [DWIDTH-1:0][6:0] sr_q, sr_d;
    logic [2:0]             seed_q, seed_d;
    logic [7:0]             good_q, good_d;
    logic [7:0]             loss_q, loss_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
    logic [DWIDTH-1:0]      err_lane_q, err_lane_d;
    logic [DWIDTH-1:0]      stuck_q, stuck_d;
    logic                   locked_q, locked_d;

    logic [DWIDTH-1:0]      pred, mis;
    logic [DWIDTH-1:0][6:0] sr_rx, sr_pr;
    logic                   any_zero;
    logic [PCW-1:0]         pop;
    logic [SW-1:0]          sum;
    logic [ERR_W-1:0]       cnt_sat;

    always_comb begin : lane_math
        pred     = '0;
        mis      = '0;
        sr_rx    = '0;
        sr_pr    = '0;
        any_zero = 1'b0;
        pop      = '0;
        for (int unsigned k = 0; k < DWIDTH; k++) begin
            pred[k]  = sr_q[k][6] ^ sr_q[k][5];
            mis[k]   = rx.i_data[k] ^ pred[k];
            sr_rx[k] = {sr_q[k][5:0], rx.i_data[k]};
            sr_pr[k] = {sr_q[k][5:0], pred[k]};
            if (sr_rx[k] == 7'd0) begin
                any_zero = 1'b1;
            end
            pop = pop + PCW'(mis[k]);
        end
        sum     = SW'(err_cnt_q) + SW'(pop);
        cnt_sat = (sum[SW-1:ERR_W] != '0) ? '1 : sum[ERR_W-1:0];
    end

    always_comb begin : next_state
        state_d    = state_q;
        sr_d       = sr_q;
        seed_d     = seed_q;
        good_d     = good_q;
        loss_d     = loss_q;
        err_cnt_d  = err_cnt_q;
        err_lane_d = err_lane_q;

        if (!i_en) begin
            state_d = ST_IDLE;
            sr_d    = '0;
            seed_d  = '0;
            good_d  = '0;
            loss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SEED;
                ST_SEED: begin
                    if (rx.i_valid) begin
                        sr_d = sr_rx;
                        if (seed_q == 3'd6) begin
                            state_d = ST_HUNT;
                            seed_d  = '0;
                            good_d  = '0;
                        end else begin
                            seed_d = seed_q + 3'd1;
                        end
                    end
                end
                ST_HUNT: begin
                    if (rx.i_valid) begin
                        sr_d = sr_rx;
                        // an all-zero lane is self-consistent, so it must veto lock explicitly
                        if (mis == '0 && !any_zero) begin
                            if (good_q == LOCK_LAST) begin
                                state_d = ST_LOCKED;
                                good_d  = '0;
                                loss_d  = '0;
                            end else begin
                                good_d = good_q + 8'd1;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
                default: begin
                    if (rx.i_valid) begin
                        sr_d       = sr_pr;
                        err_cnt_d  = cnt_sat;
                        err_lane_d = err_lane_q | mis;
                        if (mis != '0) begin
                            if (loss_q == LOSS_LAST) begin
                                state_d = ST_SEED;
                                sr_d    = '0;
                                seed_d  = '0;
                                good_d  = '0;
                                loss_d  = '0;
                            end else begin
                                loss_d = loss_q + 8'd1;
                            end
                        end else begin
                            loss_d = '0;
                        end
                    end
                end
            endcase
        end

        if (i_clr) begin
            err_cnt_d  = '0;
            err_lane_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
        stuck_d  = '0;
        if (state_d == ST_HUNT || state_d == ST_LOCKED) begin
            for (int unsigned k = 0; k < DWIDTH; k++) begin
                stuck_d[k] = (sr_d[k] == 7'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            seed_q     <= '0;
            good_q     <= '0;
            loss_q     <= '0;
            err_cnt_q  <= '0;
            err_lane_q <= '0;
            stuck_q    <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            seed_q     <= seed_d;
            good_q     <= good_d;
            loss_q     <= loss_d;
            err_cnt_q  <= err_cnt_d;
            err_lane_q <= err_lane_d;
            stuck_q    <= stuck_d;
            locked_q   <= locked_d;
        end
    end

    assign o_locked     = locked_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_err_lane   = err_lane_q;
    assign o_stuck_lane = stuck_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_emib_lane_prbs_chk.sv
// Directed bench for emib_lane_prbs_chk: per-lane PRBS7 sources, a vector table for the
// main lock/error flow and hand-written sequences for stuck, swap, saturation, gaps, enable and reset.
module tb_emib_lane_prbs_chk;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clr;
    always #5 clk = ~clk;

    emib_lane_prbs_chk_if #(.DWIDTH(40)) bus ();

    logic        a_locked;
    logic [15:0] a_err_cnt;
    logic [39:0] a_err_lane, a_stuck;
    logic [1:0]  a_state;

    logic        s_locked;
    logic [3:0]  s_err_cnt;
    logic [39:0] s_err_lane, s_stuck;
    logic [1:0]  s_state;

    emib_lane_prbs_chk #(.DWIDTH(40), .LOCK_CNT(16), .LOSS_BEATS(4), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_clr(clr), .rx(bus),
        .o_locked(a_locked), .o_err_cnt(a_err_cnt), .o_err_lane(a_err_lane),
        .o_stuck_lane(a_stuck), .o_state(a_state)
    );

    emib_lane_prbs_chk #(.DWIDTH(40), .LOCK_CNT(16), .LOSS_BEATS(255), .ERR_W(4)) dut_s (
        .clk(clk), .rst(rst), .i_en(en), .i_clr(clr), .rx(bus),
        .o_locked(s_locked), .o_err_cnt(s_err_cnt), .o_err_lane(s_err_lane),
        .o_stuck_lane(s_stuck), .o_state(s_state)
    );

    typedef struct {
        int          n;
        bit          v;
        bit          c;
        logic [39:0] flip;
        logic [1:0]  st;
        bit          lk;
        logic [15:0] cnt;
        logic [39:0] lane;
    } vec_t;

    vec_t        tbl [14];
    logic [6:0]  gen [40];
    bit          stuck12;
    bit          swap;
    logic [39:0] last_d;
    int          n_chk;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic init_gen();
        for (int k = 0; k < 40; k++) gen[k] = 7'(k + 1);
    endtask

    // One clock: valid beats advance every lane source; outputs sampled 1ns after the edge.
    task automatic step(input bit v, input logic [39:0] flip);
        logic [39:0] d;
        logic        b;
        logic        t;
        d = {8'($urandom), $urandom};
        if (v) begin
            for (int k = 0; k < 40; k++) begin
                b      = gen[k][6] ^ gen[k][5];
                gen[k] = {gen[k][5:0], b};
                d[k]   = b;
            end
            if (stuck12) d[12] = 1'b0;
            if (swap) begin
                t    = d[0];
                d[0] = d[1];
                d[1] = t;
            end
        end
        d           = d ^ flip;
        bus.i_valid = v;
        bus.i_data  = d;
        @(posedge clk);
        #1;
        last_d = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; swap = 1'b0; stuck12 = 1'b0;
        step(1'b0, '0);
        step(1'b0, '0);
        rst = 1'b0;
        init_gen();
    endtask

    task automatic lock_up();
        en = 1'b1;
        step(1'b0, '0);
        for (int i = 0; i < 23; i++) step(1'b1, '0);
    endtask

    initial begin
        int consec;
        int exp_cnt;
        int vcnt;
        bit v;
        n_chk = 0;
        n_fail = 0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        tbl[0]  = '{1,   0, 0, 40'h0,  2'd1, 0, 16'd0, 40'h0};
        tbl[1]  = '{6,   1, 0, 40'h0,  2'd1, 0, 16'd0, 40'h0};
        tbl[2]  = '{1,   1, 0, 40'h0,  2'd2, 0, 16'd0, 40'h0};
        tbl[3]  = '{15,  1, 0, 40'h0,  2'd2, 0, 16'd0, 40'h0};
        tbl[4]  = '{1,   1, 0, 40'h0,  2'd3, 1, 16'd0, 40'h0};
        tbl[5]  = '{3,   0, 0, 40'h0,  2'd3, 1, 16'd0, 40'h0};
        tbl[6]  = '{977, 1, 0, 40'h0,  2'd3, 1, 16'd0, 40'h0};
        tbl[7]  = '{1,   1, 0, 40'h20, 2'd3, 1, 16'd1, 40'h20};
        tbl[8]  = '{1,   1, 0, 40'h0,  2'd3, 1, 16'd1, 40'h20};
        tbl[9]  = '{1,   1, 0, 40'h08, 2'd3, 1, 16'd2, 40'h28};
        tbl[10] = '{1,   1, 1, 40'h0,  2'd3, 1, 16'd0, 40'h0};
        tbl[11] = '{3,   1, 0, 40'h80, 2'd3, 1, 16'd3, 40'h80};
        tbl[12] = '{1,   1, 0, 40'h80, 2'd1, 0, 16'd4, 40'h80};
        tbl[13] = '{1,   1, 1, 40'h80, 2'd1, 0, 16'd0, 40'h0};

        do_reset();
        rst = 1'b1;
        step(1'b1, '0);
        check("rst_state", 64'(a_state), 64'd0);
        check("rst_locked", 64'(a_locked), 64'd0);
        check("rst_err_cnt", 64'(a_err_cnt), 64'd0);
        check("rst_err_lane", 64'(a_err_lane), 64'd0);
        check("rst_stuck", 64'(a_stuck), 64'd0);
        rst = 1'b0;
        init_gen();

        // Main lock / single-error / clear / loss flow
        en = 1'b1;
        for (int e = 0; e < 14; e++) begin
            clr = tbl[e].c;
            for (int i = 0; i < tbl[e].n; i++) step(tbl[e].v, tbl[e].flip);
            clr = 1'b0;
            check($sformatf("tbl%0d_state", e), 64'(a_state), 64'(tbl[e].st));
            check($sformatf("tbl%0d_locked", e), 64'(a_locked), 64'(tbl[e].lk));
            check($sformatf("tbl%0d_err_cnt", e), 64'(a_err_cnt), 64'(tbl[e].cnt));
            check($sformatf("tbl%0d_err_lane", e), 64'(a_err_lane), 64'(tbl[e].lane));
            check($sformatf("tbl%0d_stuck", e), 64'(a_stuck), 64'd0);
        end

        // Lane 12 tied low never locks
        do_reset();
        stuck12 = 1'b1;
        en = 1'b1;
        step(1'b0, '0);
        for (int i = 0; i < 6; i++) step(1'b1, '0);
        check("stuck_seed_flags", 64'(a_stuck), 64'd0);
        step(1'b1, '0);
        check("stuck_hunt_state", 64'(a_state), 64'd2);
        check("stuck_hunt_flags", 64'(a_stuck), 64'h1000);
        for (int i = 0; i < 60; i++) step(1'b1, '0);
        check("stuck_late_state", 64'(a_state), 64'd2);
        check("stuck_late_locked", 64'(a_locked), 64'd0);
        check("stuck_late_flags", 64'(a_stuck), 64'h1000);
        stuck12 = 1'b0;

        // Lanes 0/1 swapped after lock: lose lock after 4 consecutive errored beats
        do_reset();
        lock_up();
        check("swap_pre_locked", 64'(a_locked), 64'd1);
        swap = 1'b1;
        consec = 0;
        exp_cnt = 0;
        for (int i = 0; i < 500 && consec < 4; i++) begin
            step(1'b1, '0);
            if (last_d[0] != last_d[1]) begin
                consec++;
                exp_cnt += 2;
            end else begin
                consec = 0;
            end
        end
        swap = 1'b0;
        check("swap_loss_reached", 64'(consec), 64'd4);
        check("swap_state", 64'(a_state), 64'd1);
        check("swap_locked", 64'(a_locked), 64'd0);
        check("swap_err_lane", 64'(a_err_lane), 64'h3);
        check("swap_err_cnt", 64'(a_err_cnt), 64'(exp_cnt));

        // Drop enable mid-HUNT: IDLE next cycle, error state held
        for (int i = 0; i < 7; i++) step(1'b1, '0);
        check("reseed_hunt_state", 64'(a_state), 64'd2);
        en = 1'b0;
        step(1'b1, '0);
        check("en_drop_state", 64'(a_state), 64'd0);
        check("en_drop_err_cnt", 64'(a_err_cnt), 64'(exp_cnt));
        check("en_drop_err_lane", 64'(a_err_lane), 64'h3);
        check("en_drop_stuck", 64'(a_stuck), 64'd0);

        // Reset while locked clears everything
        lock_up();
        check("relock_locked", 64'(a_locked), 64'd1);
        step(1'b1, 40'h1);
        check("relock_err_cnt", 64'(a_err_cnt), 64'(exp_cnt + 1));
        rst = 1'b1;
        step(1'b1, '1);
        rst = 1'b0;
        check("rstlk_state", 64'(a_state), 64'd0);
        check("rstlk_locked", 64'(a_locked), 64'd0);
        check("rstlk_err_cnt", 64'(a_err_cnt), 64'd0);
        check("rstlk_err_lane", 64'(a_err_lane), 64'd0);
        check("rstlk_stuck", 64'(a_stuck), 64'd0);

        // Saturation on the 4-bit counter instance, then clear beating an errored beat
        do_reset();
        lock_up();
        check("sat_locked", 64'(s_locked), 64'd1);
        step(1'b1, 40'h200);
        check("sat_one_cnt", 64'(s_err_cnt), 64'd1);
        check("sat_one_lane", 64'(s_err_lane), 64'h200);
        step(1'b1, '1);
        check("sat_all_cnt", 64'(s_err_cnt), 64'd15);
        check("sat_all_lane", 64'(s_err_lane), 64'hFF_FFFF_FFFF);
        step(1'b1, '1);
        check("sat_nowrap_cnt", 64'(s_err_cnt), 64'd15);
        check("sat_still_locked", 64'(s_state), 64'd3);
        clr = 1'b1;
        step(1'b1, '1);
        clr = 1'b0;
        check("clr_err_cnt", 64'(s_err_cnt), 64'd0);
        check("clr_err_lane", 64'(s_err_lane), 64'd0);
        check("clr_state", 64'(s_state), 64'd3);

        // Sparse valid: lock after exactly 23 valid beats
        do_reset();
        en = 1'b1;
        step(1'b0, '0);
        vcnt = 0;
        for (int i = 0; i < 2000 && vcnt < 23; i++) begin
            v = ($urandom_range(0, 99) < 30);
            step(v, '0);
            if (v) begin
                vcnt++;
                if (vcnt == 22) begin
                    check("gap_22_locked", 64'(a_locked), 64'd0);
                    check("gap_22_state", 64'(a_state), 64'd2);
                end
            end
        end
        check("gap_beats_reached", 64'(vcnt), 64'd23);
        check("gap_23_locked", 64'(a_locked), 64'd1);
        check("gap_23_state", 64'(a_state), 64'd3);
        for (int i = 0; i < 5; i++) step(1'b0, '1);
        check("gap_hold_err_cnt", 64'(a_err_cnt), 64'd0);
        check("gap_hold_locked", 64'(a_locked), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
